// File: rtl/gray_counter.sv
// Up/down binary counter whose value is published as reflected Gray code
// through a registered valid/ready output stage with a one-cycle wrap pulse.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] gray_reg;
    logic             valid_reg;
    logic             wrap_reg;

    logic             stall;
    logic             step;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] src_bin;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // A code still waiting for the consumer freezes counting; load does not.
    assign stall = valid_reg & ~out_ready;
    assign step  = en & ~load & ~stall;

    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (up_dn) begin
            bin_next  = bin_reg + ONE;
            wrap_next = (bin_reg == ALL_ONES);
        end else begin
            bin_next  = bin_reg - ONE;
            wrap_next = (bin_reg == '0);
        end
    end

    assign src_bin = load ? load_val : bin_next;

    // Gray encode of the value about to be registered: g[i] = b[i] ^ b[i+1].
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = src_bin[gi] ^ src_bin[gi+1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = src_bin[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg   <= '0;
            gray_reg  <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else if (load) begin
            bin_reg   <= load_val;
            gray_reg  <= gray_next;
            valid_reg <= 1'b1;
            wrap_reg  <= 1'b0;
        end else if (step) begin
            bin_reg   <= bin_next;
            gray_reg  <= gray_next;
            valid_reg <= 1'b1;
            wrap_reg  <= wrap_next;
        end else if (stall) begin
            // Everything visible holds, including a pending wrap pulse.
            wrap_reg  <= wrap_reg;
        end else begin
            if (valid_reg && out_ready) begin
                valid_reg <= 1'b0;
            end
            wrap_reg <= 1'b0;
        end
    end

    assign gray_out  = gray_reg;
    assign out_valid = valid_reg;
    assign wrap      = wrap_reg;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Up/down binary counter that registers its value as reflected Gray code, with a valid/ready output handshake.
- Upstream neighbour of the Gray-to-binary converter: gray_out feeds the converter's input directly.
- Typical uses: pointer and position generation where only one output bit may change per step.
- Supports synchronous load of a binary start value, a direction control, and a wrap indication.

Parameters:
- WIDTH, 4, counter and Gray code width in bits (minimum 2).

Ports:
- clk        input   1      system clock; all state updates on rising edge
- rst        input   1      synchronous reset, active-high
- en         input   1      request to advance the counter by one
- up_dn      input   1      direction: 1 = increment, 0 = decrement
- load       input   1      load load_val this cycle (priority over en)
- load_val   input   WIDTH  binary value to load
- gray_out   output  WIDTH  registered Gray code of internal count
- out_valid  output  1      gray_out holds a code not yet consumed
- out_ready  input   1      consumer accepts gray_out this cycle
- wrap       output  1      last step crossed the all-ones/zero boundary

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Internal state: binary register bin[WIDTH-1:0]. The encoding is gray(x) = x ^ (x >> 1).
- Reset (rst=1 at a clk edge) overrides all other inputs. It sets:
  - bin = 0
  - gray_out = 0
  - out_valid = 0
  - wrap = 0
- Reset asserted mid-sequence discards any pending code; the next cycle starts from 0.
- stall = out_valid & ~out_ready.
- step = en & ~load & ~stall.
- Priority per edge: rst > load > step > handshake-only.
- Load (load=1):
  - bin <= load_val; gray_out <= gray(load_val); out_valid <= 1; wrap <= 0.
  - Load ignores stall and overwrites any unconsumed code.
- Step:
  - bin_n = bin + 1 (up_dn=1) or bin - 1 (up_dn=0), modulo 2^WIDTH.
  - Updates: bin <= bin_n; gray_out <= gray(bin_n); out_valid <= 1.
  - wrap <= 1 when the step goes all-ones -> 0 (up) or 0 -> all-ones (down); otherwise wrap <= 0.
- No load and no step:
  - bin and gray_out hold.
  - If out_valid & out_ready, then out_valid <= 0.
  - wrap <= 0, so wrap is a one-cycle pulse aligned with the wrapped code.
- Latency: a new code appears on gray_out one cycle after the accepting edge.
- Throughput: with out_ready held high and en=1, one code per cycle.
- Handshake:
  - While stalled, gray_out, out_valid and wrap hold; en is ignored and no count is lost or skipped.
  - A transfer is out_valid & out_ready. In the same cycle, en=1 may produce the next code (back-to-back).
- Consecutive codes produced by steps differ in exactly one bit, including across wrap.
- up_dn is sampled only on step cycles. Changing direction between steps is legal; the next code still differs in one bit.
- All outputs are registers; there is no combinational path from inputs to outputs.

Test Plan (WIDTH=4):
1. Reset: drive rst=1 for 2 cycles with en=1 and load=1 -> gray_out=0000, out_valid=0, wrap=0. The cycle after release with en=1 and out_ready=1 -> gray_out=0001.
2. Up count: out_ready=1, up_dn=1, en=1 for 16 cycles from reset.
   - Expected codes: 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
   - wrap=1 only with the final 0000.
   - Each code differs from the previous one by exactly one bit.
3. Down wrap: from reset, one step with up_dn=0 -> gray_out=1000 with wrap=1. Next down step -> 1001 with wrap=0.
4. Load: load=1, load_val=0101, en=1 -> gray_out=0111, out_valid=1, wrap=0. One up step -> 0101 (bin 6).
5. Backpressure: reach gray_out=0011, then set out_ready=0 and en=1 for 5 cycles -> gray_out stays 0011 with out_valid=1. Then set out_ready=1 -> the next edge gives 0010 (no skipped code).
6. Drain and reset mid-operation:
   - en=0, out_ready=1 for one cycle -> out_valid falls to 0 and gray_out holds.
   - Then assert rst while at 1101 with en=1 -> gray_out=0000, out_valid=0 after that edge.
